// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mem_arbiter
//  Purpose  : Shares one in-order memory port between instruction fetch and
//             data memory, routing in-order responses via a tag FIFO.
//             Build option RISCV_MEM_ARB_DM_PRIO_EN selects fixed data priority.
//  Revision : 1.0
// ============================================================================
module riscv_mem_arbiter #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req_vld,
    input  logic [31:0]       if_req_addr,
    output logic              if_req_ack,
    output logic              if_rsp_vld,
    output logic [31:0]       if_rsp_addr,
    output logic [31:0]       if_rsp_data,
    input  logic              if_rsp_ack,
    input  logic              dm_req_vld,
    input  logic              dm_req_rnw,
    input  logic [31:0]       dm_req_addr,
    input  logic [31:0]       dm_req_data,
    output logic              dm_req_ack,
    output logic              dm_rsp_vld,
    output logic [31:0]       dm_rsp_addr,
    output logic [31:0]       dm_rsp_data,
    input  logic              dm_rsp_ack,
    output logic              mem_req_vld,
    output logic              mem_req_rnw,
    output logic [31:0]       mem_req_addr,
    output logic [31:0]       mem_req_data,
    input  logic              mem_req_ack,
    input  logic              mem_rsp_vld,
    input  logic [31:0]       mem_rsp_addr,
    input  logic [31:0]       mem_rsp_data,
    output logic              mem_rsp_ack,
    output logic [CNT_W-1:0]  outstanding,
    output logic              err_orphan_rsp
);

    localparam int         c_PTR_W = $clog2(DEPTH);
    localparam logic       c_ID_IF = 1'b0;
    localparam logic       c_ID_DM = 1'b1;

    logic                  r_last_grant;
    logic                  r_lock;
    logic                  r_locked_id;
    logic [DEPTH-1:0]      r_tag_mem;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_orphan;

    logic                  w_grant;
    logic                  w_gnt_vld;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_head;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_head  = r_tag_mem[r_rd_ptr];

    always_comb begin
        w_grant = c_ID_IF;
        if (r_lock) begin
            w_grant = r_locked_id;
        end else if (if_req_vld && dm_req_vld) begin
`ifdef RISCV_MEM_ARB_DM_PRIO_EN
            w_grant = c_ID_DM;
`else
            w_grant = ~r_last_grant;
`endif
        end else if (dm_req_vld) begin
            w_grant = c_ID_DM;
        end
    end

    // Outputs are forced quiet while reset is asserted.
    assign w_gnt_vld    = (w_grant == c_ID_DM) ? dm_req_vld : if_req_vld;
    assign mem_req_vld  = w_gnt_vld & ~w_full & ~reset;
    assign mem_req_rnw  = (w_grant == c_ID_DM) ? dm_req_rnw : 1'b1;
    assign mem_req_addr = (w_grant == c_ID_DM) ? dm_req_addr : if_req_addr;
    assign mem_req_data = (w_grant == c_ID_DM) ? dm_req_data : 32'h0;
    assign w_accept     = mem_req_vld & mem_req_ack;
    assign if_req_ack   = w_accept & (w_grant == c_ID_IF);
    assign dm_req_ack   = w_accept & (w_grant == c_ID_DM);

    always_comb begin
        if_rsp_vld  = 1'b0;
        dm_rsp_vld  = 1'b0;
        mem_rsp_ack = 1'b0;
        if (!reset) begin
            if (w_empty) begin
                mem_rsp_ack = mem_rsp_vld;
            end else if (w_head == c_ID_DM) begin
                dm_rsp_vld  = mem_rsp_vld;
                mem_rsp_ack = dm_rsp_ack;
            end else begin
                if_rsp_vld  = mem_rsp_vld;
                mem_rsp_ack = if_rsp_ack;
            end
        end
    end

    assign if_rsp_addr    = mem_rsp_addr;
    assign if_rsp_data    = mem_rsp_data;
    assign dm_rsp_addr    = mem_rsp_addr;
    assign dm_rsp_data    = mem_rsp_data;
    assign w_pop          = mem_rsp_vld & mem_rsp_ack & ~w_empty;
    assign outstanding    = r_count;
    assign err_orphan_rsp = r_orphan;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= c_ID_DM;
            r_lock       <= 1'b0;
            r_locked_id  <= c_ID_IF;
            r_tag_mem    <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_orphan     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_grant        <= w_grant;
                r_lock              <= 1'b0;
                r_tag_mem[r_wr_ptr] <= w_grant;
                r_wr_ptr            <= r_wr_ptr + 1'b1;
            end else if (mem_req_vld) begin
                // Hold the stalled grant so the downstream request stays stable.
                r_lock      <= 1'b1;
                r_locked_id <= w_grant;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (mem_rsp_vld && w_empty) begin
                r_orphan <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_mem_arbiter
//  Purpose  : Directed self-checking bench for riscv_mem_arbiter.
//  Revision : 1.0
// ============================================================================
module tb_riscv_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req_vld, if_req_ack, if_rsp_vld, if_rsp_ack;
    logic [31:0] if_req_addr, if_rsp_addr, if_rsp_data;
    logic        dm_req_vld, dm_req_rnw, dm_req_ack, dm_rsp_vld, dm_rsp_ack;
    logic [31:0] dm_req_addr, dm_req_data, dm_rsp_addr, dm_rsp_data;
    logic        mem_req_vld, mem_req_rnw, mem_req_ack, mem_rsp_vld, mem_rsp_ack;
    logic [31:0] mem_req_addr, mem_req_data, mem_rsp_addr, mem_rsp_data;
    logic [4:0]  outstanding;
    logic        err_orphan_rsp;

    int n_checks = 0;
    int n_errors = 0;

`ifdef RISCV_MEM_ARB_DM_PRIO_EN
    localparam bit c_DM_PRIO = 1'b1;
`else
    localparam bit c_DM_PRIO = 1'b0;
`endif

    always #5 clock = ~clock;

    riscv_mem_arbiter #(.DEPTH(16)) dut (
        .clock(clock), .reset(reset),
        .if_req_vld(if_req_vld), .if_req_addr(if_req_addr), .if_req_ack(if_req_ack),
        .if_rsp_vld(if_rsp_vld), .if_rsp_addr(if_rsp_addr), .if_rsp_data(if_rsp_data),
        .if_rsp_ack(if_rsp_ack),
        .dm_req_vld(dm_req_vld), .dm_req_rnw(dm_req_rnw), .dm_req_addr(dm_req_addr),
        .dm_req_data(dm_req_data), .dm_req_ack(dm_req_ack),
        .dm_rsp_vld(dm_rsp_vld), .dm_rsp_addr(dm_rsp_addr), .dm_rsp_data(dm_rsp_data),
        .dm_rsp_ack(dm_rsp_ack),
        .mem_req_vld(mem_req_vld), .mem_req_rnw(mem_req_rnw), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_ack(mem_req_ack),
        .mem_rsp_vld(mem_rsp_vld), .mem_rsp_addr(mem_rsp_addr), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_ack(mem_rsp_ack),
        .outstanding(outstanding), .err_orphan_rsp(err_orphan_rsp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        if_req_vld = 0; if_req_addr = 0; if_rsp_ack = 0;
        dm_req_vld = 0; dm_req_rnw = 1; dm_req_addr = 0; dm_req_data = 0; dm_rsp_ack = 0;
        mem_req_ack = 0; mem_rsp_vld = 0; mem_rsp_addr = 0; mem_rsp_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    initial begin
        logic exp_dm;
        idle_inputs();
        reset = 1;

        // Reset cycle: requests and responses offered, everything must stay quiet.
        if_req_vld = 1; dm_req_vld = 1; mem_req_ack = 1; mem_rsp_vld = 1;
        if_rsp_ack = 1; dm_rsp_ack = 1;
        tick();
        settle();
        check("rst_mem_req_vld", 32'(mem_req_vld), 0);
        check("rst_if_req_ack", 32'(if_req_ack), 0);
        check("rst_dm_req_ack", 32'(dm_req_ack), 0);
        check("rst_mem_rsp_ack", 32'(mem_rsp_ack), 0);
        check("rst_rsp_vld", 32'({if_rsp_vld, dm_rsp_vld}), 0);
        do_reset();
        check("rst_outstanding", 32'(outstanding), 0);
        check("rst_err", 32'(err_orphan_rsp), 0);

        // Round-robin with both requesters always valid.
        if_req_vld = 1; if_req_addr = 32'h100;
        dm_req_vld = 1; dm_req_addr = 32'h200; dm_req_data = 32'hDEAD;
        mem_req_ack = 1;
        for (int i = 0; i < 4; i++) begin
            exp_dm = c_DM_PRIO ? 1'b1 : (i % 2 == 1);
            settle();
            check("rr_addr", mem_req_addr, exp_dm ? 32'h200 : 32'h100);
            check("rr_wdata", mem_req_data, exp_dm ? 32'hDEAD : 32'h0);
            check("rr_if_ack", 32'(if_req_ack), 32'(!exp_dm));
            check("rr_dm_ack", 32'(dm_req_ack), 32'(exp_dm));
            tick();
            check("rr_outstanding", 32'(outstanding), 32'(i + 1));
        end

        // Stalled grant is held while the other requester waits.
        do_reset();
        if_req_vld = 1; if_req_addr = 32'h100;
        dm_req_vld = 1; dm_req_addr = 32'h200;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("lock_addr", mem_req_addr, c_DM_PRIO ? 32'h200 : 32'h100);
            check("lock_vld", 32'(mem_req_vld), 1);
            check("lock_noack", 32'({if_req_ack, dm_req_ack}), 0);
            tick();
        end
        mem_req_ack = 1;
        settle();
        check("lock_release_addr", mem_req_addr, c_DM_PRIO ? 32'h200 : 32'h100);
        check("lock_release_ack", 32'({if_req_ack, dm_req_ack}), c_DM_PRIO ? 32'b01 : 32'b10);
        tick();
        settle();
        check("lock_next_dm", mem_req_addr, 32'h200);
        check("lock_next_dm_ack", 32'(dm_req_ack), 1);

        // Three requests and three in-order responses.
        do_reset();
        mem_req_ack = 1;
        if_req_vld = 1; if_req_addr = 32'h10;
        tick();
        if_req_vld = 0; dm_req_vld = 1; dm_req_rnw = 1; dm_req_addr = 32'h20;
        settle();
        check("io_dm_rnw", 32'(mem_req_rnw), 1);
        tick();
        dm_req_vld = 0; if_req_vld = 1; if_req_addr = 32'h30;
        tick();
        if_req_vld = 0;
        check("io_outstanding3", 32'(outstanding), 3);
        if_rsp_ack = 1; dm_rsp_ack = 1; mem_rsp_vld = 1;
        mem_rsp_addr = 32'h10; mem_rsp_data = 32'hA;
        settle();
        check("io_rsp1_route", 32'({if_rsp_vld, dm_rsp_vld}), 32'b10);
        check("io_rsp1_data", if_rsp_data, 32'hA);
        check("io_rsp1_ack", 32'(mem_rsp_ack), 1);
        tick();
        mem_rsp_addr = 32'h20; mem_rsp_data = 32'hB;
        settle();
        check("io_rsp2_route", 32'({if_rsp_vld, dm_rsp_vld}), 32'b01);
        check("io_rsp2_data", dm_rsp_data, 32'hB);
        check("io_rsp2_addr", dm_rsp_addr, 32'h20);
        tick();
        mem_rsp_addr = 32'h30; mem_rsp_data = 32'hC;
        settle();
        check("io_rsp3_route", 32'({if_rsp_vld, dm_rsp_vld}), 32'b10);
        check("io_rsp3_data", if_rsp_data, 32'hC);
        tick();
        mem_rsp_vld = 0;
        check("io_outstanding0", 32'(outstanding), 0);
        check("io_no_orphan", 32'(err_orphan_rsp), 0);

        // Fill the tag FIFO, then free one slot.
        do_reset();
        mem_req_ack = 1; if_req_vld = 1; if_req_addr = 32'h400;
        for (int i = 0; i < 16; i++) tick();
        settle();
        check("full_outstanding", 32'(outstanding), 16);
        check("full_req_vld", 32'(mem_req_vld), 0);
        check("full_req_ack", 32'(if_req_ack), 0);
        mem_rsp_vld = 1; if_rsp_ack = 1;
        settle();
        check("full_pop_ack", 32'(mem_rsp_ack), 1);
        check("full_pop_no_push", 32'(mem_req_vld), 0);
        tick();
        mem_rsp_vld = 0;
        check("full_after_pop", 32'(outstanding), 15);
        settle();
        check("full_accept_again", 32'(if_req_ack), 1);
        tick();
        check("full_refill", 32'(outstanding), 16);

        // Stalled data response while fetch keeps issuing.
        do_reset();
        mem_req_ack = 1;
        dm_req_vld = 1; dm_req_rnw = 0; dm_req_addr = 32'h40; dm_req_data = 32'h55;
        settle();
        check("st_wr_rnw", 32'(mem_req_rnw), 0);
        check("st_wr_data", mem_req_data, 32'h55);
        tick();
        dm_req_vld = 0;
        if_req_vld = 1; if_req_addr = 32'h500;
        mem_rsp_vld = 1; mem_rsp_data = 32'h77; dm_rsp_ack = 0; if_rsp_ack = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("st_dm_vld", 32'(dm_rsp_vld), 1);
            check("st_if_rsp_vld", 32'(if_rsp_vld), 0);
            check("st_mem_rsp_ack", 32'(mem_rsp_ack), 0);
            check("st_if_req_ack", 32'(if_req_ack), 1);
            tick();
        end
        check("st_outstanding", 32'(outstanding), 5);
        if_req_vld = 0; dm_rsp_ack = 1;
        settle();
        check("st_release_ack", 32'(mem_rsp_ack), 1);
        tick();
        mem_rsp_vld = 0;
        check("st_after_pop", 32'(outstanding), 4);

        // Orphan response with an empty tag FIFO.
        do_reset();
        mem_rsp_vld = 1; if_rsp_ack = 0; dm_rsp_ack = 0;
        settle();
        check("orph_ack", 32'(mem_rsp_ack), 1);
        check("orph_no_route", 32'({if_rsp_vld, dm_rsp_vld}), 0);
        check("orph_err_same", 32'(err_orphan_rsp), 0);
        tick();
        mem_rsp_vld = 0;
        check("orph_err_set", 32'(err_orphan_rsp), 1);
        tick();
        check("orph_err_hold", 32'(err_orphan_rsp), 1);
        do_reset();
        check("orph_err_clear", 32'(err_orphan_rsp), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
Two-requester arbiter that shares the single in-order memory request/response port of the core's AXI driver between the instruction-fetch unit (read-only) and the data-memory unit (read/write). It selects one requester per cycle and holds the grant while a request is stalled. It records the requester of every accepted request in an in-order tag FIFO, and routes each returning response back to that requester. It sits between the pipeline fetch/LSU and the AXI driver.

Parameters:
DEPTH, 16, tag FIFO entries; sets the maximum number of outstanding accepted requests (power of two, >=2).
CNT_W, $clog2(DEPTH)+1, width of the outstanding counter.

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
if_req_vld  in  1  fetch request valid (always a read)
if_req_addr  in  32  fetch address
if_req_ack  out  1  fetch request accepted this cycle
if_rsp_vld  out  1  fetch response valid
if_rsp_addr  out  32  fetch response address
if_rsp_data  out  32  fetch response data
if_rsp_ack  in  1  fetch consumes response
dm_req_vld  in  1  data request valid
dm_req_rnw  in  1  1=read, 0=write
dm_req_addr  in  32  data address
dm_req_data  in  32  write data
dm_req_ack  out  1  data request accepted
dm_rsp_vld  out  1  data response valid
dm_rsp_addr  out  32  data response address
dm_rsp_data  out  32  data response data
dm_rsp_ack  in  1  data consumes response
mem_req_vld  out  1  downstream request valid
mem_req_rnw  out  1  downstream read/not-write
mem_req_addr  out  32  downstream address
mem_req_data  out  32  downstream write data
mem_req_ack  in  1  downstream accepted request
mem_rsp_vld  in  1  downstream response valid (in order, one per accepted request, reads and writes)
mem_rsp_addr  in  32  downstream response address
mem_rsp_data  in  32  downstream response data
mem_rsp_ack  out  1  response consumed
outstanding  out  CNT_W  tag FIFO occupancy
err_orphan_rsp  out  1  sticky: a response arrived with the tag FIFO empty

Behaviour:
- Reset: last_grant=DM (fetch wins the first tie), lock clear, FIFO pointers 0, outstanding=0, err_orphan_rsp=0. All *_ack and *_vld outputs are 0 in the reset cycle. A reset mid-transaction discards all tags.
- Grant selection is combinational:
  - If lock is set, grant=locked_id.
  - Otherwise, if only one requester is valid, grant that requester.
  - If both are valid, grant the requester other than last_grant (round-robin).
- mem_req_vld = granted requester's vld & ~fifo_full. mem_req_rnw is 1 for fetch and dm_req_rnw for data. mem_req_addr and mem_req_data come from the granted requester; mem_req_data is 0 for fetch.
- Accept condition: mem_req_vld & mem_req_ack. On accept:
  - Assert the granted requester's req_ack the same cycle (zero added latency).
  - Push the grant id into the FIFO.
  - last_grant <= grant.
  - Clear the lock.
- Lock: if mem_req_vld=1 and mem_req_ack=0, set lock <= 1 and locked_id <= grant. The grant is held until accept, so a stalled request's contents stay stable downstream.
- FIFO full (outstanding==DEPTH): mem_req_vld=0, no acks, lock unchanged.
- Response routing:
  - If the FIFO is non-empty, the head id selects the target requester. Its rsp_vld = mem_rsp_vld; addr and data pass through; mem_rsp_ack = the target's rsp_ack. The other requester's rsp_vld=0.
  - Pop on mem_rsp_vld & mem_rsp_ack.
- Orphan response: if mem_rsp_vld=1 with the FIFO empty, drive mem_rsp_ack=1 (drop it), set err_orphan_rsp (cleared only by reset), and present no response upstream.
- Simultaneous push and pop: outstanding is unchanged, and both pointers advance modulo DEPTH.
- Pop with FIFO empty never occurs. Push when full is blocked by the gating above.
- A same-cycle response for a request being accepted that cycle is impossible (the FIFO would be empty); such a response is treated as an orphan.

Optional Feature:
RISCV_MEM_ARB_DM_PRIO_EN
- Defined: fixed priority; data wins whenever dm_req_vld=1 and no lock is held. last_grant is still updated but ignored.
- Undefined: round-robin as above.
- Lock and FIFO behaviour are identical in both builds.

Test Plan:
- Both valid every cycle, mem_req_ack=1, addrs IF=0x100, DM=0x200 -> grants alternate IF,DM,IF,DM; outstanding increments by 1 per cycle. With RISCV_MEM_ARB_DM_PRIO_EN defined: DM on every cycle.
- IF granted at 0x100 and mem_req_ack held 0 for 3 cycles while dm_req_vld=1 -> mem_req_addr stays 0x100 all 3 cycles; on ack, if_req_ack=1 and the next grant is DM.
- Accept IF 0x10, DM read 0x20, IF 0x30; return 3 in-order responses with data 0xA,0xB,0xC -> if_rsp gets 0xA then 0xC, dm_rsp gets 0xB; outstanding returns to 0.
- Fill 16 requests with no responses -> outstanding=16, mem_req_vld=0, no req_ack. One response popped the same cycle as a pending request -> next accept allowed, outstanding stays 16.
- DM response stalled (dm_rsp_ack=0 for 4 cycles) while mem_rsp_vld=1 -> mem_rsp_ack=0 and head unchanged; IF requests are still accepted meanwhile.
- mem_rsp_vld=1 after reset with no requests -> mem_rsp_ack=1, err_orphan_rsp=1 from the next cycle and held; a later reset clears it.
